// File: rtl/pingpang_reader_if.sv
// -----------------------------------------------------------------------------
// pingpang_reader_if
//   Bundles the bus-side signals of pingpang_reader: the control and read-data
//   channels of the two AXI burst read masters and the output word stream.
//
//   Master side (pingpang_reader):
//     INIT_AXI_RXN_1/2       out  one-cycle burst start pulse per AXI master
//     INIT_AXI_RXN_DONE_1/2  in   one-cycle pulse, last beat of burst accepted
//     BIAS_ADDR_1/2          out  byte offset of the burst for each AXI master
//     M_1/2_AXI_RDATA        in   read beat
//     M_1/2_AXI_RVALID       in   beat valid
//     M_1/2_AXI_RREADY       out  beat accept
//     data, data_valid       out  output word and its valid
//     data_ready             in   downstream accept
//   Slave side: the AXI masters and the downstream sink (mirror directions).
// -----------------------------------------------------------------------------
interface pingpang_reader_if #(
  parameter int ADDR_WIDTH         = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
);
  logic                          INIT_AXI_RXN_1;
  logic                          INIT_AXI_RXN_2;
  logic                          INIT_AXI_RXN_DONE_1;
  logic                          INIT_AXI_RXN_DONE_2;
  logic [ADDR_WIDTH-1:0]         BIAS_ADDR_1;
  logic [ADDR_WIDTH-1:0]         BIAS_ADDR_2;
  logic [C_M_AXI_DATA_WIDTH-1:0] M_1_AXI_RDATA;
  logic [C_M_AXI_DATA_WIDTH-1:0] M_2_AXI_RDATA;
  logic                          M_1_AXI_RVALID;
  logic                          M_2_AXI_RVALID;
  logic                          M_1_AXI_RREADY;
  logic                          M_2_AXI_RREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0] data;
  logic                          data_valid;
  logic                          data_ready;

  modport master (
    output INIT_AXI_RXN_1, INIT_AXI_RXN_2, BIAS_ADDR_1, BIAS_ADDR_2,
    output M_1_AXI_RREADY, M_2_AXI_RREADY, data, data_valid,
    input  INIT_AXI_RXN_DONE_1, INIT_AXI_RXN_DONE_2,
    input  M_1_AXI_RDATA, M_2_AXI_RDATA, M_1_AXI_RVALID, M_2_AXI_RVALID,
    input  data_ready
  );

  modport slave (
    input  INIT_AXI_RXN_1, INIT_AXI_RXN_2, BIAS_ADDR_1, BIAS_ADDR_2,
    input  M_1_AXI_RREADY, M_2_AXI_RREADY, data, data_valid,
    output INIT_AXI_RXN_DONE_1, INIT_AXI_RXN_DONE_2,
    output M_1_AXI_RDATA, M_2_AXI_RDATA, M_1_AXI_RVALID, M_2_AXI_RVALID,
    output data_ready
  );
endinterface

// File: rtl/pingpang_reader.sv
// -----------------------------------------------------------------------------
// pingpang_reader
//   Streams the byte region [0, End_ADDR) back out as an in-order word stream
//   by alternating two AXI burst read masters: while one master's burst drains
//   into the output register, the other master's next burst is already issued.
//   Only whole bursts that fit below End_ADDR are read.
//
//   Optional feature: define PINGPANG_READER_THROTTLE_EN to stop new bursts
//   being issued while the sink FIFO is nearly full (hysteresis between
//   WARNING_THRES and WARNING_CANCEL_THRES). Without it, throttled is 0 and
//   the FIFO level inputs are ignored.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     start                    rising edge in IDLE launches a pass
//     End_ADDR                 region length in bytes
//     Sink_FIFO_Counter        sink FIFO level
//     WARNING_THRES            level at/above which throttling starts
//     WARNING_CANCEL_THRES     level at/below which throttling stops
//     bus                      AXI master control/read channels + output
//                              stream (see pingpang_reader_if)
//     Read_done                high while the pass is complete (DONE)
//     throttled                throttle flag
//     current_state            FSM state, for debug
// -----------------------------------------------------------------------------
module pingpang_reader #(
  parameter int C_M_AXI_BURST_LEN  = 16,
  parameter int ADDR_WIDTH         = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int FIFO_Counter_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         End_ADDR,
  input  logic [FIFO_Counter_WIDTH-1:0] Sink_FIFO_Counter,
  input  logic [FIFO_Counter_WIDTH-1:0] WARNING_THRES,
  input  logic [FIFO_Counter_WIDTH-1:0] WARNING_CANCEL_THRES,
  pingpang_reader_if.master             bus,
  output logic                          Read_done,
  output logic                          throttled,
  output logic [2:0]                    current_state
);

  localparam int BURST_BYTES = C_M_AXI_BURST_LEN * C_M_AXI_DATA_WIDTH / 8;

  // Burst length widened by one bit so that offset + burst never wraps.
  localparam logic [ADDR_WIDTH:0]   BURST_BYTES_X = (ADDR_WIDTH+1)'(BURST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] BIAS_2_INIT   = ADDR_WIDTH'(BURST_BYTES);
  // Each master owns every other burst, so it advances by two bursts.
  localparam logic [ADDR_WIDTH-1:0] BIAS_STEP     = ADDR_WIDTH'(2 * BURST_BYTES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    READ1 = 3'd2,
    READ2 = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Engine owning the next burst in address order.
  typedef enum logic {
    ENG1 = 1'b0,
    ENG2 = 1'b1
  } engine_t;

  state_t                        state_q, state_d;
  engine_t                       turn_q, turn_d;
  logic                          pending_1_q, pending_1_d;
  logic                          pending_2_q, pending_2_d;
  logic [ADDR_WIDTH-1:0]         bias_1_q, bias_1_d;
  logic [ADDR_WIDTH-1:0]         bias_2_q, bias_2_d;
  logic                          init_1_q, init_1_d;
  logic                          init_2_q, init_2_d;
  logic                          start_q, start_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic                          data_valid_q, data_valid_d;
  logic                          read_done_q, read_done_d;
  logic                          throttled_q, throttled_d;

  logic fits_1;
  logic fits_2;
  logic out_free;
  logic rready_1;
  logic rready_2;

  assign fits_1   = ({1'b0, bias_1_q} + BURST_BYTES_X) <= {1'b0, End_ADDR};
  assign fits_2   = ({1'b0, bias_2_q} + BURST_BYTES_X) <= {1'b0, End_ADDR};
  // The output register can take a beat if it is empty or being drained now.
  assign out_free = !data_valid_q || bus.data_ready;

  // ---------------------------------------------------------------------------
  // Sink FIFO throttle register
  // ---------------------------------------------------------------------------
`ifdef PINGPANG_READER_THROTTLE_EN
  always_comb begin
    throttled_d = throttled_q;
    // Set has priority when both thresholds are met.
    if (Sink_FIFO_Counter >= WARNING_THRES) begin
      throttled_d = 1'b1;
    end else if (Sink_FIFO_Counter <= WARNING_CANCEL_THRES) begin
      throttled_d = 1'b0;
    end
  end
`else
  logic unused_throttle_inputs;
  assign unused_throttle_inputs = ^{Sink_FIFO_Counter, WARNING_THRES, WARNING_CANCEL_THRES};
  assign throttled_d            = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM: next state, burst bookkeeping, read-channel accept
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d     = state_q;
    turn_d      = turn_q;
    pending_1_d = pending_1_q;
    pending_2_d = pending_2_q;
    bias_1_d    = bias_1_q;
    bias_2_d    = bias_2_q;
    init_1_d    = 1'b0;
    init_2_d    = 1'b0;
    rready_1    = 1'b0;
    rready_2    = 1'b0;
    start_d     = start;
    read_done_d = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (start && !start_q) begin
          state_d     = ISSUE;
          bias_1_d    = '0;
          bias_2_d    = BIAS_2_INIT;
          turn_d      = ENG1;
          pending_1_d = 1'b0;
          pending_2_d = 1'b0;
        end
      end

      ISSUE: begin
        if (turn_q == ENG1) begin
          if (!fits_1) begin
            state_d = DONE;
          end else if (!throttled_q) begin
            init_1_d    = 1'b1;
            pending_1_d = 1'b1;
            state_d     = READ1;
          end
        end else begin
          if (!fits_2) begin
            state_d = DONE;
          end else if (!throttled_q) begin
            init_2_d    = 1'b1;
            pending_2_d = 1'b1;
            state_d     = READ2;
          end
        end
      end

      READ1: begin
        rready_1 = out_free;
        // Prefetch the other engine's burst while this one drains.
        if (!pending_2_q && fits_2 && !throttled_q && !bus.INIT_AXI_RXN_DONE_1) begin
          init_2_d    = 1'b1;
          pending_2_d = 1'b1;
        end
        if (bus.INIT_AXI_RXN_DONE_1 && pending_1_q) begin
          pending_1_d = 1'b0;
          bias_1_d    = bias_1_q + BIAS_STEP;
          turn_d      = ENG2;
          state_d     = pending_2_q ? READ2 : ISSUE;
        end
      end

      READ2: begin
        rready_2 = out_free;
        if (!pending_1_q && fits_1 && !throttled_q && !bus.INIT_AXI_RXN_DONE_2) begin
          init_1_d    = 1'b1;
          pending_1_d = 1'b1;
        end
        if (bus.INIT_AXI_RXN_DONE_2 && pending_2_q) begin
          pending_2_d = 1'b0;
          bias_2_d    = bias_2_q + BIAS_STEP;
          turn_d      = ENG1;
          state_d     = pending_1_q ? READ1 : ISSUE;
        end
      end

      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register: only the master owning the current burst can be accepted,
  // so at most one load source is active in any cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    data_d       = data_q;
    data_valid_d = data_valid_q;
    if (bus.M_1_AXI_RVALID && rready_1) begin
      data_d       = bus.M_1_AXI_RDATA;
      data_valid_d = 1'b1;
    end else if (bus.M_2_AXI_RVALID && rready_2) begin
      data_d       = bus.M_2_AXI_RDATA;
      data_valid_d = 1'b1;
    end else if (bus.data_ready) begin
      data_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= IDLE;
      turn_q       <= ENG1;
      pending_1_q  <= 1'b0;
      pending_2_q  <= 1'b0;
      bias_1_q     <= '0;
      bias_2_q     <= BIAS_2_INIT;
      init_1_q     <= 1'b0;
      init_2_q     <= 1'b0;
      start_q      <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      read_done_q  <= 1'b0;
      throttled_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      turn_q       <= turn_d;
      pending_1_q  <= pending_1_d;
      pending_2_q  <= pending_2_d;
      bias_1_q     <= bias_1_d;
      bias_2_q     <= bias_2_d;
      init_1_q     <= init_1_d;
      init_2_q     <= init_2_d;
      start_q      <= start_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      read_done_q  <= read_done_d;
      throttled_q  <= throttled_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.INIT_AXI_RXN_1 = init_1_q;
  assign bus.INIT_AXI_RXN_2 = init_2_q;
  assign bus.BIAS_ADDR_1    = bias_1_q;
  assign bus.BIAS_ADDR_2    = bias_2_q;
  assign bus.M_1_AXI_RREADY = rready_1;
  assign bus.M_2_AXI_RREADY = rready_2;
  assign bus.data           = data_q;
  assign bus.data_valid     = data_valid_q;
  assign Read_done          = read_done_q;
  assign throttled          = throttled_q;
  assign current_state      = state_q;

endmodule

// File: tb/tb_pingpang_reader.sv
// -----------------------------------------------------------------------------
// tb_pingpang_reader
//   Drives pingpang_reader with two behavioural AXI burst masters whose memory
//   word at each byte offset equals the offset, and checks the output stream,
//   burst issue order, reset behaviour, back-pressure and throttling against
//   expectations computed from the region length.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pingpang_reader;

  localparam int LEN = 16;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int FW  = 8;
  localparam int BB  = LEN * DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] end_addr;
  logic [FW-1:0] fifo_cnt;
  logic [FW-1:0] thres;
  logic [FW-1:0] cancel;
  logic          read_done;
  logic          throttled;
  logic [2:0]    cur_state;

  int            checks = 0;
  int            errors = 0;
  logic [31:0]   exp_word;
  int            words;
  int            init_cnt;
  int            init2_cnt;
  logic [1:0]    prev_init;
  bit            rand_ready;

  always #5 clk = ~clk;

  pingpang_reader_if #(.ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) bus ();

  pingpang_reader #(
    .C_M_AXI_BURST_LEN (LEN),
    .ADDR_WIDTH        (AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .FIFO_Counter_WIDTH(FW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .End_ADDR            (end_addr),
    .Sink_FIFO_Counter   (fifo_cnt),
    .WARNING_THRES       (thres),
    .WARNING_CANCEL_THRES(cancel),
    .bus                 (bus),
    .Read_done           (read_done),
    .throttled           (throttled),
    .current_state       (cur_state)
  );

  // ---------------------------------------------------------------------------
  // Behavioural AXI burst read masters: on INIT, serve LEN beats starting at
  // the captured offset, data = byte offset, random RVALID gaps; DONE pulses
  // in the cycle the last beat is accepted.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < 2; k++) begin : g_mst
    logic          rvalid;
    logic          done;
    logic [DW-1:0] rdata;
    logic          hs;
    logic          init_seen;
    logic [AW-1:0] bias_seen;
    logic [AW-1:0] addr;
    int            left;
    wire           rready = (k == 0) ? bus.M_1_AXI_RREADY : bus.M_2_AXI_RREADY;
    wire           init   = (k == 0) ? bus.INIT_AXI_RXN_1  : bus.INIT_AXI_RXN_2;
    wire [AW-1:0]  bias   = (k == 0) ? bus.BIAS_ADDR_1     : bus.BIAS_ADDR_2;

    initial begin
      rvalid = 1'b0; done = 1'b0; rdata = '0; hs = 1'b0;
      init_seen = 1'b0; bias_seen = '0; addr = '0; left = 0;
      forever begin
        @(negedge clk);
        hs        = rvalid && rready;
        done      = hs && (left == 1);
        init_seen = init;
        bias_seen = bias;
        @(posedge clk);
        #2;
        if (rst) begin
          left   = 0;
          rvalid = 1'b0;
          done   = 1'b0;
        end else begin
          if (hs) begin
            left = left - 1;
            addr = addr + 32'd4;
          end
          if (init_seen) begin
            left = LEN;
            addr = bias_seen;
          end
          done   = 1'b0;
          rvalid = (left > 0) && ($urandom_range(0, 3) != 0);
          rdata  = addr;
        end
      end
    end
  end

  assign bus.M_1_AXI_RVALID      = g_mst[0].rvalid;
  assign bus.M_2_AXI_RVALID      = g_mst[1].rvalid;
  assign bus.M_1_AXI_RDATA       = g_mst[0].rdata;
  assign bus.M_2_AXI_RDATA       = g_mst[1].rdata;
  assign bus.INIT_AXI_RXN_DONE_1 = g_mst[0].done;
  assign bus.INIT_AXI_RXN_DONE_2 = g_mst[1].done;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor at the falling edge, then step past the rising edge.
  task automatic cycle();
    logic [1:0] cur_init;
    @(negedge clk);
    if (bus.data_valid && bus.data_ready) begin
      check("word_order", bus.data, exp_word);
      exp_word = exp_word + 32'd4;
      words++;
    end
    cur_init = {bus.INIT_AXI_RXN_2, bus.INIT_AXI_RXN_1};
    if (cur_init != 2'b00) begin
      check("init_engine", cur_init, (init_cnt % 2 == 0) ? 2'b01 : 2'b10);
      check("init_bias", cur_init[0] ? bus.BIAS_ADDR_1 : bus.BIAS_ADDR_2, init_cnt * BB);
      check("init_one_cycle", prev_init & cur_init, 0);
      if (cur_init[1]) init2_cnt++;
      init_cnt++;
    end
    prev_init = cur_init;
    if (bus.M_1_AXI_RREADY && bus.M_2_AXI_RREADY)
      check("rready_exclusive", 2'b11, 2'b00);
    @(posedge clk);
    #1;
    if (rand_ready) bus.data_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Launch a pass and check the first two edges after start is sampled.
  task automatic begin_pass(input int unsigned e_addr, input bit hot_fifo);
    end_addr  = e_addr;
    exp_word  = 0;
    words     = 0;
    init_cnt  = 0;
    init2_cnt = 0;
    start     = 1'b1;
    cycle();
    check("issue_after_start", cur_state, 1);
    if (hot_fifo) fifo_cnt = 8'd200;
    cycle();
    if (e_addr >= BB) begin
      check("first_init1", bus.INIT_AXI_RXN_1, 1);
      check("first_bias1", bus.BIAS_ADDR_1, 0);
      check("first_read1", cur_state, 2);
    end else begin
      check("short_done_state", cur_state, 4);
      check("short_no_init", {bus.INIT_AXI_RXN_2, bus.INIT_AXI_RXN_1}, 0);
      check("short_done_late", read_done, 0);
      cycle();
      check("short_read_done", read_done, 1);
    end
  endtask

  // Run to completion, drain, and return to IDLE.
  task automatic finish_pass(input int unsigned e_addr);
    int budget = 0;
    while (read_done !== 1'b1 && budget < 3000) begin
      cycle();
      budget++;
    end
    check("done_reached", read_done, 1);
    rand_ready     = 1'b0;
    bus.data_ready = 1'b1;
    repeat (3) cycle();
    check("word_count", words, (e_addr / BB) * LEN);
    check("burst_count", init_cnt, e_addr / BB);
    check("drained", bus.data_valid, 0);
    start = 1'b0;
    cycle();
    cycle();
    check("back_to_idle", cur_state, 0);
    check("read_done_low", read_done, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int b;
    int stall_words;
    rst            = 1'b1;
    start          = 1'b0;
    end_addr       = '0;
    fifo_cnt       = '0;
    thres          = 8'd192;
    cancel         = 8'd64;
    bus.data_ready = 1'b1;
    rand_ready     = 1'b0;
    prev_init      = 2'b00;
    exp_word       = 0;
    words          = 0;
    init_cnt       = 0;
    init2_cnt      = 0;

    #12;
    check("rst_state", cur_state, 0);
    check("rst_init", {bus.INIT_AXI_RXN_2, bus.INIT_AXI_RXN_1}, 0);
    check("rst_rready", {bus.M_2_AXI_RREADY, bus.M_1_AXI_RREADY}, 0);
    check("rst_valid", bus.data_valid, 0);
    check("rst_data", bus.data, 0);
    check("rst_done", read_done, 0);
    check("rst_throttled", throttled, 0);
    check("rst_bias1", bus.BIAS_ADDR_1, 0);
    check("rst_bias2", bus.BIAS_ADDR_2, BB);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full four-burst pass, sink always ready.
    begin_pass(256, 1'b0);
    finish_pass(256);

    // Region shorter than one burst: nothing issued.
    begin_pass(32, 1'b0);
    finish_pass(32);

    // Three bursts with a ten-cycle sink stall mid-burst.
    begin_pass(192, 1'b0);
    b = 0;
    while (words < 8 && b < 500) begin
      cycle();
      b++;
    end
    check("stall_reached", words >= 8, 1);
    bus.data_ready = 1'b0;
    cycle();
    cycle();
    stall_words = words;
    check("stall_in_read1", cur_state, 2);
    check("m2_early_untouched", g_mst[1].left, LEN);
    repeat (8) begin
      cycle();
      check("stall_rready1", bus.M_1_AXI_RREADY, 0);
      check("stall_rready2", bus.M_2_AXI_RREADY, 0);
      check("stall_valid_held", bus.data_valid, 1);
    end
    check("stall_no_words", words, stall_words);
    bus.data_ready = 1'b1;
    finish_pass(192);

    // Sink FIFO near full while burst 1 drains.
    begin_pass(256, 1'b1);
    b = 0;
    while (words < 16 && b < 500) begin
      cycle();
      b++;
    end
    repeat (3) cycle();
`ifdef PINGPANG_READER_THROTTLE_EN
    check("thr_no_prefetch", init2_cnt, 0);
    check("thr_flag_set", throttled, 1);
    check("thr_waiting", cur_state, 1);
    fifo_cnt = 8'd100;
    cycle();
    check("thr_hysteresis", throttled, 1);
    fifo_cnt = 8'd64;
    cycle();
    check("thr_cleared", throttled, 0);
    cycle();
    check("thr_init2", bus.INIT_AXI_RXN_2, 1);
    check("thr_bias2", bus.BIAS_ADDR_2, BB);
`else
    check("nothr_prefetch", init2_cnt, 1);
    check("nothr_flag", throttled, 0);
    fifo_cnt = 8'd64;
`endif
    finish_pass(256);
    fifo_cnt = '0;

    // Asynchronous reset in the middle of a READ2 burst, then replay.
    rand_ready = 1'b1;
    begin_pass(256, 1'b0);
    b = 0;
    while (cur_state !== 3'd3 && b < 500) begin
      cycle();
      b++;
    end
    check("reached_read2", cur_state, 3);
    rst = 1'b1;
    #1;
    check("arst_state", cur_state, 0);
    check("arst_init", {bus.INIT_AXI_RXN_2, bus.INIT_AXI_RXN_1}, 0);
    check("arst_rready", {bus.M_2_AXI_RREADY, bus.M_1_AXI_RREADY}, 0);
    check("arst_valid", bus.data_valid, 0);
    check("arst_data", bus.data, 0);
    check("arst_done", read_done, 0);
    check("arst_bias1", bus.BIAS_ADDR_1, 0);
    check("arst_bias2", bus.BIAS_ADDR_2, BB);
    start = 1'b0;
    rand_ready = 1'b0;
    bus.data_ready = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    begin_pass(256, 1'b0);
    finish_pass(256);

    // Random region lengths with random sink back-pressure.
    for (int i = 0; i < 3; i++) begin
      int unsigned e;
      e = $urandom_range(0, 600);
      rand_ready = 1'b1;
      begin_pass(e, 1'b0);
      finish_pass(e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pingpang_reader.md
# pingpang_reader

Read-side counterpart of the ping-pong DMA writer. Streams the memory region [0, End_ADDR) (byte offsets, added to the base address inside each AXI read master) back out as an in-order word stream. Alternates two AXI burst read masters so that the next burst is always in flight while the current one drains. Optional sink-FIFO throttling stops new bursts being issued when the downstream FIFO is nearly full.

## Interface
- C_M_AXI_BURST_LEN, 16, beats per burst
- ADDR_WIDTH, 32, offset width
- C_M_AXI_DATA_WIDTH, 32, beat width; BURST_BYTES = C_M_AXI_BURST_LEN*C_M_AXI_DATA_WIDTH/8
- FIFO_Counter_WIDTH, 8, sink FIFO level width

Ports:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  level; rising edge in IDLE launches a pass
- End_ADDR  in  ADDR_WIDTH  region length in bytes
- Sink_FIFO_Counter, WARNING_THRES, WARNING_CANCEL_THRES  in  FIFO_Counter_WIDTH  throttle inputs
- INIT_AXI_RXN_1/2  out  1  one-cycle burst start pulse to master 1/2
- INIT_AXI_RXN_DONE_1/2  in  1  one-cycle pulse: master's last beat accepted
- BIAS_ADDR_1/2  out  ADDR_WIDTH  burst offset for master 1/2
- M_1_AXI_RDATA/M_2_AXI_RDATA  in  C_M_AXI_DATA_WIDTH  read beat
- M_1_AXI_RVALID/M_2_AXI_RVALID  in  1  beat valid
- M_1_AXI_RREADY/M_2_AXI_RREADY  out  1  beat accept
- data  out  C_M_AXI_DATA_WIDTH  output word
- data_valid  out  1;  data_ready  in  1  valid/ready output handshake
- Read_done  out  1  high while in DONE
- throttled  out  1  throttle flag
- current_state  out  3  FSM state, debug

## Operation
- States: IDLE=0, ISSUE=1, READ1=2, READ2=3, DONE=4; other codes → IDLE.
- Registers: turn (engine owning next burst in order, 1 or 2), pending_1/2 (burst issued, DONE not yet seen).
- IDLE: on start rising edge → ISSUE; BIAS_ADDR_1←0, BIAS_ADDR_2←BURST_BYTES, turn←1, pending←0.
- fits_k = (BIAS_ADDR_k + BURST_BYTES <= End_ADDR), computed in ADDR_WIDTH+1 bits (no wrap).
- ISSUE: if !fits_turn → DONE; else if throttled wait; else pulse INIT_AXI_RXN_turn, set pending_turn, → READturn.
- READk: M_k_AXI_RREADY = !data_valid | data_ready; other master's RREADY = 0. On INIT_AXI_RXN_DONE_k: clear pending_k, BIAS_ADDR_k += 2*BURST_BYTES, turn ← other j; → READj if pending_j, else → ISSUE.
- Prefetch in READk: pulse INIT_AXI_RXN_j when !pending_j & fits_j & !throttled & !INIT_AXI_RXN_DONE_k; sets pending_j same edge.
- DONE: Read_done=1; start low → IDLE.
- start is ignored outside IDLE/DONE (no abort).
- Output register: loads M_k_AXI_RDATA when M_k_AXI_RVALID & M_k_AXI_RREADY; data_valid clears on data_ready without new load. Words leave in strict address order.
- DONE_k outside READk or with pending_k=0: ignored (no address change).

## Timing
- Reset (async, immediate): state IDLE, all INIT/RREADY/data_valid/Read_done/throttled 0, data 0, BIAS_ADDR_1 0, BIAS_ADDR_2 BURST_BYTES. Masters share rst.
- INIT pulses exactly one cycle; BIAS_ADDR_k stable from INIT_k until DONE_k.
- Beat accepted at edge n → data/data_valid valid after edge n (latency 1); full throughput with data_ready held high.
- start sampled high at edge 0 → ISSUE after edge 0 → first INIT_AXI_RXN_1 high after edge 1.
- Throttle register: set when Sink_FIFO_Counter >= WARNING_THRES, cleared when <= WARNING_CANCEL_THRES; set wins if both. Only gates new INIT pulses; in-flight bursts complete.

## Configuration
- PINGPANG_READER_THROTTLE_EN defined: throttle as above.
- Undefined: throttled tied 0, threshold/counter inputs ignored; bursts issue without sink gating.

## Test plan
- BURST_LEN=16, 32-bit, End_ADDR=256, memory word = offset, data_ready=1 → INIT order 1@0, 2@64, 1@128, 2@192; 64 words 0,4,…,252 in order; Read_done high; start low → IDLE.
- End_ADDR=32 → no INIT pulses; Read_done high after edge 2 of start sample.
- End_ADDR=192 → three bursts (1,2,1), 48 words, no INIT_AXI_RXN_2 for offset 192.
- data_ready low 10 cycles mid-burst, master 2 data arriving early → RREADY_1 drops, RREADY_2 stays 0 until READ2; no word lost/duplicated/reordered.
- THRES=192, CANCEL=64, counter=200 during READ1 → no prefetch INIT_2; counter=64 → throttled clears, INIT_2 issues; with macro undefined INIT_2 issues immediately.
- rst pulsed mid-READ2 → outputs zero asynchronously; after release, new start replays from offset 0.
